// File: rtl/stopwatch_ctrl_fsm.sv
// stopwatch_ctrl_fsm: button conditioning and run/lap/stop sequencer for the BCD stopwatch counter
// Ports:
//    i_rtcclk      rtc clock, rising edge
//    i_reset_n     asynchronous active-low reset
//    i_startstop   raw start/stop button, active high
//    i_lapreset    raw lap/reset button, active high
//    i_count       BCD count fed back from the counter
//    o_countenb    counter count enable
//    o_countinit   counter synchronous clear
//    o_latchcount  1 = display tracks count, 0 = lap hold
//    o_state       00 IDLE, 01 RUN, 10 LAP, 11 STOP
module stopwatch_ctrl_fsm #(
   parameter int          DEBOUNCE_CNT = 3,
   parameter logic [23:0] MAX_COUNT    = 24'h595999,
   parameter bit          STOP_AT_MAX  = 1'b1
) (
   input  logic        i_rtcclk,
   input  logic        i_reset_n,
   input  logic        i_startstop,
   input  logic        i_lapreset,
   input  logic [23:0] i_count,
   output logic        o_countenb,
   output logic        o_countinit,
   output logic        o_latchcount,
   output logic [1:0]  o_state
);
   localparam int CW = $clog2(DEBOUNCE_CNT > 1 ? DEBOUNCE_CNT : 2);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, LAP = 2'b10, STOP = 2'b11} state_t;
   state_t state, state_nxt;
   logic [1:0] s1, s2, deb, deb_q, press;
   logic [CW-1:0] cnt [2];
   logic ss, lr, at_max;
   assign press  = deb & ~deb_q;
   assign ss     = press[0];
   assign lr     = press[1];
   assign at_max = STOP_AT_MAX && (i_count == MAX_COUNT);
   // bit 0 = start/stop, bit 1 = lap/reset; a level flips only after DEBOUNCE_CNT differing samples
   always_ff @(posedge i_rtcclk or negedge i_reset_n)
      if (!i_reset_n) begin
         s1     <= '0;
         s2     <= '0;
         deb    <= '0;
         deb_q  <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         s1    <= {i_lapreset, i_startstop};
         s2    <= s1;
         deb_q <= deb;
         for (int i = 0; i < 2; i++)
            if (s2[i] == deb[i]) cnt[i] <= '0;
            else if (cnt[i] == CW'(DEBOUNCE_CNT - 1)) begin
               deb[i] <= s2[i];
               cnt[i] <= '0;
            end else cnt[i] <= cnt[i] + CW'(1);
      end
   always_ff @(posedge i_rtcclk or negedge i_reset_n)
      if (!i_reset_n) state <= IDLE;
      else state <= state_nxt;
   // start/stop has priority; a simultaneous lap/reset press is dropped
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = ss ? RUN : IDLE;
         RUN:     state_nxt = (at_max || ss) ? STOP : lr ? LAP : RUN;
         LAP:     state_nxt = (at_max || ss) ? STOP : lr ? RUN : LAP;
         STOP:    state_nxt = ss ? (at_max ? STOP : RUN) : lr ? IDLE : STOP;
         default: state_nxt = IDLE;
      endcase
   end
   assign o_countinit  = state == IDLE;
   assign o_latchcount = state != LAP;
   assign o_countenb   = (state == RUN || state == LAP) && !at_max;
   assign o_state      = state;
endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// tb_stopwatch_ctrl_fsm: self-checking bench with a sample-window reference model
module tb_stopwatch_ctrl_fsm;
   localparam int D = 3;
   localparam logic [23:0] MAX = 24'h595999;
   logic clk = 0, rst_n = 0, ss = 0, lr = 0;
   logic [23:0] cnt = '0;
   logic enb1, init1, latch1, enb2, init2, latch2;
   logic [1:0] st1, st2;
   int checks = 0, errors = 0;
   int mst = 0;
   bit lvl [2];
   bit ev [2];
   bit q0 [$];
   bit q1 [$];
   stopwatch_ctrl_fsm #(.DEBOUNCE_CNT(D), .MAX_COUNT(MAX), .STOP_AT_MAX(1'b1)) dut1 (
      .i_rtcclk(clk), .i_reset_n(rst_n), .i_startstop(ss), .i_lapreset(lr), .i_count(cnt),
      .o_countenb(enb1), .o_countinit(init1), .o_latchcount(latch1), .o_state(st1));
   stopwatch_ctrl_fsm #(.DEBOUNCE_CNT(D), .MAX_COUNT(MAX), .STOP_AT_MAX(1'b0)) dut2 (
      .i_rtcclk(clk), .i_reset_n(rst_n), .i_startstop(ss), .i_lapreset(lr), .i_count(cnt),
      .o_countenb(enb2), .o_countinit(init2), .o_latchcount(latch2), .o_state(st2));
   always #5 clk = ~clk;
   task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
      end
   endtask
   function automatic int nxt(int s, bit p_ss, bit p_lr, bit mx);
      if (s == 1 || s == 2) begin
         if (mx || p_ss) return 3;
         if (p_lr) return s == 1 ? 2 : 1;
         return s;
      end
      if (s == 3) return p_ss ? (mx ? 3 : 1) : (p_lr ? 0 : 3);
      return p_ss ? 1 : 0;
   endfunction
   function automatic bit window_differs(input bit q [$], input bit l);
      int n = q.size();
      if (n < D + 2) return 0;
      for (int i = n - 2 - D; i <= n - 3; i++) if (q[i] == l) return 0;
      return 1;
   endfunction
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mst = 0;
         lvl[0] = 0; lvl[1] = 0;
         ev[0] = 0;  ev[1] = 0;
         q0.delete(); q1.delete();
      end else begin
         mst = nxt(mst, ev[0], ev[1], cnt == MAX);
         q0.push_back(ss);
         q1.push_back(lr);
         ev[0] = 0; ev[1] = 0;
         if (window_differs(q0, lvl[0])) begin lvl[0] = !lvl[0]; ev[0] = lvl[0]; end
         if (window_differs(q1, lvl[1])) begin lvl[1] = !lvl[1]; ev[1] = lvl[1]; end
      end
   end
   initial forever begin
      @(negedge clk);
      #2;
      check("model_state", st1, mst);
      check("model_init", init1, mst == 0);
      check("model_latch", latch1, mst != 2);
      check("model_enb", enb1, (mst == 1 || mst == 2) && cnt != MAX);
   end
   task automatic press(input bit s, input bit l);
      @(negedge clk);
      ss = s; lr = l;
      repeat (6) @(negedge clk);
      ss = 0; lr = 0;
      repeat (8) @(negedge clk);
      #3;
   endtask
   initial begin
      #1;
      check("rst_init", init1, 1);
      check("rst_enb", enb1, 0);
      check("rst_latch", latch1, 1);
      check("rst_state", st1, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      #3;
      check("post_rst_state", st1, 0);
      check("post_rst_init", init1, 1);
      @(negedge clk);
      ss = 1;
      repeat (2) @(negedge clk);
      ss = 0;
      repeat (8) @(negedge clk);
      #3;
      check("glitch_state", st1, 0);
      @(negedge clk);
      ss = 1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("latency_edge%0d", k), st1, k == 6 ? 1 : 0);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      ss = 0;
      repeat (10) @(negedge clk);
      #3;
      check("hold_one_event", st1, 1);
      press(0, 1);
      check("lap_state", st1, 2);
      check("lap_latch", latch1, 0);
      check("lap_enb", enb1, 1);
      press(0, 1);
      check("lap_run_state", st1, 1);
      check("run_latch", latch1, 1);
      press(1, 0);
      check("stop_state", st1, 3);
      check("stop_enb", enb1, 0);
      press(0, 1);
      check("idle_state", st1, 0);
      check("idle_init", init1, 1);
      press(1, 0);
      check("run2_state", st1, 1);
      press(1, 1);
      check("both_state", st1, 3);
      press(0, 1);
      check("both_idle", st1, 0);
      press(1, 0);
      press(0, 1);
      check("pre_rst_lap", st1, 2);
      @(negedge clk);
      #3 rst_n = 0;
      #1;
      check("async_state", st1, 0);
      check("async_init", init1, 1);
      check("async_enb", enb1, 0);
      check("async_latch", latch1, 1);
      #2 rst_n = 1;
      repeat (3) @(negedge clk);
      #3;
      check("after_pulse", st1, 0);
      press(1, 0);
      check("max_run1", st1, 1);
      check("max_run2", st2, 1);
      @(negedge clk);
      cnt = 24'h595998;
      #3;
      check("below_max_enb", enb1, 1);
      @(negedge clk);
      cnt = MAX;
      #3;
      check("max_enb1", enb1, 0);
      check("max_enb2", enb2, 1);
      @(posedge clk);
      #1;
      check("max_stop1", st1, 3);
      check("max_run_nostop2", st2, 1);
      check("max_enb2_after", enb2, 1);
      press(1, 0);
      check("max_stay_stop", st1, 3);
      @(negedge clk);
      cnt = 24'h000000;
      press(1, 0);
      check("resume_run", st1, 1);
      check("resume_init", init1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
